// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: bundles the keypad matrix lines (column drive, row
// read-back) and the entry/key-event outputs of the keypad scanner.
// master: the scanner. slave: the keypad side and the downstream consumers
// (display driver, game logic).
interface keypad_scanner_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [13:0] val;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        enter;

  modport master (
    input  row,
    output col,
    output val,
    output key_code,
    output key_valid,
    output enter
  );

  modport slave (
    output row,
    input  col,
    input  val,
    input  key_code,
    input  key_valid,
    input  enter
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad one column at a time,
// debounces presses and releases over whole scan ticks, and folds accepted
// keys into a 4-digit decimal entry value with per-key event pulses.
// Optional build macro: KEYPAD_BACKSPACE_EN -- when defined, key D removes
// the last entered digit (val <- val/10); otherwise D only reports its code.
module keypad_scanner #(
  parameter int SCAN_DIV       = 65536,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic               clk,
  input logic               rst,
  keypad_scanner_if.master  kp
);

  localparam int              DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N   = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  // Key code for a (row, column) position of the matrix.
  function automatic logic [3:0] key_code_f(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = 4'd10;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = 4'd11;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = 4'd12;
      4'hC:    code = 4'd14;
      4'hD:    code = 4'd0;
      4'hE:    code = 4'd15;
      4'hF:    code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Lowest-index low row wins when several rows are pulled low together.
  function automatic logic [1:0] low_row_f(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // New entry value after accepting a key; digits shift in from the right
  // and the oldest digit drops off so the result never exceeds 9999.
  function automatic logic [13:0] next_val_f(input logic [13:0] v, input logic [3:0] code);
    logic [13:0] nv;
    if (code <= 4'd9) begin
      nv = ((v % 14'd1000) * 14'd10) + {10'd0, code};
    end else begin
      case (code)
        4'd14:   nv = 14'd0;
`ifdef KEYPAD_BACKSPACE_EN
        4'd13:   nv = v / 14'd10;
`else
        4'd13:   nv = v;
`endif
        default: nv = v;
      endcase
    end
    return nv;
  endfunction

  state_t          state_r, state_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic [1:0]      col_idx_r, col_idx_s;
  logic [1:0]      cand_row_r, cand_row_s;
  logic [3:0]      cnt_r, cnt_s;
  logic [3:0]      col_r;
  logic [13:0]     val_r, val_s;
  logic [3:0]      key_code_r, key_code_s;
  logic            key_valid_r, key_valid_s;
  logic            enter_r, enter_s;

  logic            tick_s;
  logic            pressed_s;
  logic [1:0]      low_row_s;
  logic            accept_s;
  logic [3:0]      accept_code_s;

  assign tick_s    = (div_cnt_r == DIV_MAX);
  assign pressed_s = (kp.row != 4'hF);
  assign low_row_s = low_row_f(kp.row);

  // Column dwell divider: the tick is the last cycle of each column slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Scan/debounce state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      col_idx_r   <= 2'd0;
      cand_row_r  <= 2'd0;
      cnt_r       <= 4'd0;
      col_r       <= 4'b1110;
      val_r       <= 14'd0;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      enter_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_idx_r   <= col_idx_s;
      cand_row_r  <= cand_row_s;
      cnt_r       <= cnt_s;
      col_r       <= ~(4'b0001 << col_idx_s);
      val_r       <= val_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
      enter_r     <= enter_s;
    end
  end

  // Next-state logic: rows are only looked at on a tick; the column index
  // is frozen while a candidate key is debounced or held.
  always_comb begin
    state_s    = state_r;
    col_idx_s  = col_idx_r;
    cand_row_s = cand_row_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          if (pressed_s) begin
            cand_row_s = low_row_s;
            if (DEB_N == 4'd1) begin
              accept_s = 1'b1;
              cnt_s    = 4'd0;
              state_s  = ST_RELEASE;
            end else begin
              cnt_s   = 4'd1;
              state_s = ST_DEBOUNCE;
            end
          end else begin
            col_idx_s = col_idx_r + 2'd1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_DEBOUNCE: begin
        if (tick_s) begin
          if (pressed_s && (low_row_s == cand_row_r)) begin
            if ((cnt_r + 4'd1) == DEB_N) begin
              accept_s = 1'b1;
              cnt_s    = 4'd0;
              state_s  = ST_RELEASE;
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_s     = 4'd0;
            col_idx_s = col_idx_r + 2'd1;
            state_s   = ST_IDLE;
          end
        end else begin
          state_s = ST_DEBOUNCE;
        end
      end

      ST_RELEASE: begin
        if (tick_s) begin
          if (!pressed_s) begin
            if ((cnt_r + 4'd1) == DEB_N) begin
              cnt_s     = 4'd0;
              col_idx_s = col_idx_r + 2'd1;
              state_s   = ST_IDLE;
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_s = 4'd0;
          end
        end else begin
          state_s = ST_RELEASE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Accept action: key event pulses and entry value update.
  always_comb begin
    accept_code_s = key_code_f(cand_row_s, col_idx_r);
    val_s         = val_r;
    key_code_s    = key_code_r;
    key_valid_s   = 1'b0;
    enter_s       = 1'b0;
    if (accept_s) begin
      val_s       = next_val_f(val_r, accept_code_s);
      key_code_s  = accept_code_s;
      key_valid_s = 1'b1;
      enter_s     = (accept_code_s == 4'd15);
    end else begin
      val_s = val_r;
    end
  end

  assign kp.col       = col_r;
  assign kp.val       = val_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.enter     = enter_r;

endmodule
